// File: rtl/inner_pipe_sequencer.sv
// inner_pipe_sequencer: issues float(0..N) into inner_function_pipelined and streams results to a ready/valid accumulator; SEQ_ABORT_EN adds abort
module inner_pipe_sequencer #(
  parameter int LATENCY = 60,
  parameter int IDX_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        busy,
  output logic        pipe_aclr,
  output logic        pipe_clk_en,
  output logic [31:0] pipe_dataa,
  input  logic [31:0] pipe_result,
  output logic        acc_valid,
  output logic [31:0] acc_data,
`ifdef SEQ_ABORT_EN
  input  logic        abort,
`endif
  input  logic        acc_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [IDX_W:0] ONE = 1;
  state_t state;
  logic [LATENCY-1:0] vsr;
  logic [IDX_W:0] i, n, delivered, next_del;
  logic accept, stall, ab, unused_bits;
  function automatic logic [31:0] to_float(input logic [IDX_W:0] v);
    int p;
    p = 0;
    for (int k = 0; k <= IDX_W; k++) if (v[k]) p = k;
    return v == '0 ? 32'd0 : {1'b0, 8'(127 + p), 23'({23'd0, v} << (23 - p))};
  endfunction
`ifdef SEQ_ABORT_EN
  assign ab = abort & busy;
`else
  assign ab = 1'b0;
`endif
  assign unused_bits = ^dataa[31:IDX_W];
  assign pipe_aclr = ~reset_n;
  assign acc_valid = vsr[LATENCY-1] & busy;
  assign acc_data = pipe_result;
  assign stall = acc_valid & ~acc_ready;
  assign pipe_clk_en = busy & ~stall;
  assign accept = acc_valid & acc_ready;
  assign next_del = accept ? delivered + ONE : delivered;
  assign pipe_dataa = state == ISSUE ? to_float(i) : 32'd0;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      vsr <= '0;
      i <= '0;
      n <= '0;
      delivered <= '0;
      done <= 1'b0;
      result <= '0;
      busy <= 1'b0;
    end else begin
      done <= 1'b0;
      delivered <= next_del;
      if (pipe_clk_en) vsr <= {vsr[LATENCY-2:0], state == ISSUE};
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          busy <= 1'b1;
          i <= '0;
          n <= {1'b0, dataa[IDX_W-1:0]};
          delivered <= '0;
        end
        ISSUE: if (pipe_clk_en) begin
          i <= i + ONE;
          if (i == n) state <= DRAIN;
        end
        DRAIN: if (next_del == n + ONE) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          result <= 32'(next_del);
        end
        default: state <= IDLE;
      endcase
      if (ab) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        vsr <= '0;
        result <= 32'(next_del);
      end
    end
endmodule

// File: doc/inner_pipe_sequencer.md
# inner_pipe_sequencer

Control block that drives `inner_function_pipelined` for a whole evaluation run. On a custom-instruction style `start`, it generates the integer sample points 0..N and converts each to IEEE-754 single precision. It issues one operand per enabled cycle into the pipeline and tracks in-flight operands with a valid shift register. Results stream to a downstream floating-point accumulator under ready/valid back-pressure, and `done` pulses once every result has been accepted.

## Interface
- `LATENCY`, 60: enabled-cycle latency of `inner_function_pipelined` (operand in to result out).
- `IDX_W`, 8: width of sample count N; N range 0..2^IDX_W−1.
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: begin run; sampled only in IDLE.
- `dataa` in 32: `dataa[IDX_W-1:0]` = N; upper bits ignored.
- `done` out 1: one-cycle pulse at run end.
- `result` out 32: samples delivered (N+1, or fewer on abort), zero-extended; valid while `done`=1.
- `busy` out 1: high in ISSUE/DRAIN.
- `pipe_aclr` out 1: pipeline clear = ~reset_n (combinational).
- `pipe_clk_en` out 1: pipeline advance enable.
- `pipe_dataa` out 32: float operand to pipeline.
- `pipe_result` in 32: pipeline output.
- `acc_valid` out 1: `acc_data` holds a valid result.
- `acc_data` out 32: = `pipe_result`.
- `acc_ready` in 1: downstream accepts when `acc_valid`&`acc_ready`.
- `abort` in 1: present only with `SEQ_ABORT_EN`.

## Operation
- FSM: IDLE → ISSUE (start) → DRAIN (last operand issued) → DONE (all results accepted) → IDLE (always, next cycle).
- `stall` = `acc_valid` & ~`acc_ready`; `pipe_clk_en` = ~`stall` in ISSUE/DRAIN, 0 in IDLE/DONE.
- Valid shift register `vsr[LATENCY-1:0]` advances only when `pipe_clk_en`=1. It shifts in 1 on an issue and 0 otherwise. `acc_valid` = `vsr[LATENCY-1]` & `busy`.
- Issue counter `i` (IDX_W+1 bits) is cleared on start. It increments on each cycle in ISSUE with `pipe_clk_en`=1, and ISSUE exits after issuing i=N. `pipe_dataa` = float(i) while in ISSUE, 0 otherwise.
- int→float conversion is exact, round-free: i=0 → 0x00000000. Otherwise sign 0, exponent 127+msb(i), mantissa = bits below the MSB, left-aligned. Examples: 25 → 0x41c80000, 255 → 0x437f0000.
- Delivered counter increments on each accept. DRAIN exits when delivered = N+1. `result` latches the delivered count on entry to DONE.
- `start` while busy or in DONE is ignored. N=0 issues exactly one operand (0.0).
- Reset (`reset_n`=0 at an edge) from any state: FSM to IDLE, `vsr` and counters to 0. All outputs are 0 (`done`, `result`, `busy`, `pipe_clk_en`, `pipe_dataa`, `acc_valid`) except `pipe_aclr`=1 while reset is held. In-flight results are discarded.

## Timing
- `start` sampled at edge 0 → ISSUE in cycle 1. Operand i is presented in cycle 1+i with no stalls.
- An operand presented with `pipe_clk_en`=1 in cycle t produces `acc_valid` in cycle t+LATENCY, plus one cycle per stalled cycle in between.
- With no stalls, the last result is in cycle 1+N+LATENCY, `done` in cycle 2+N+LATENCY, and IDLE in cycle 3+N+LATENCY. `start` may be reasserted in that IDLE cycle.
- A stall freezes the issue counter, `pipe_dataa`, `vsr` and pipeline contents. `acc_data` holds stable while `acc_valid`=1 and `acc_ready`=0.

## Configuration
- `SEQ_ABORT_EN` defined: adds the `abort` input. When `abort`=1 in ISSUE or DRAIN, the next state is DONE: `vsr` is cleared, issue stops, `result` = delivered count at that edge, and `done` pulses. `abort` is ignored in IDLE/DONE.
- Undefined: no `abort` port, and runs always complete.

## Test plan
- N=0, LATENCY=60, `acc_ready`=1: one `pipe_dataa`=0x00000000 in cycle 1 → `acc_valid` only in cycle 61, `done` in cycle 62, `result`=1.
- N=25, `acc_ready`=1: operands cycles 1..26, with cycle 26 = 0x41c80000 → 26 consecutive `acc_valid` cycles 61..86, `done` cycle 87, `result`=26.
- N=255 with `acc_ready` toggling every cycle → exactly 256 accepts in issue order, the final operand is 0x437f0000, `result`=256, and `acc_data` is stable across every stall.
- Start in cycle 1, pulse `reset_n` low in cycle 30 of a N=25 run → IDLE next cycle with all outputs 0. A fresh run started afterwards delivers exactly N+1 results with none stale.
- `start` reasserted mid-run → ignored: count and `done` timing unchanged.
- `SEQ_ABORT_EN` defined, N=100, `abort` after 10 accepts → `done` next cycle with `result`=10, and no further `acc_valid`.
